// File: rtl/memory_sdpram_if.sv
// Port bundle for the simple dual-port RAM: write port A, read port B.
// Latency: wires only. Backpressure: none, both ports accept every cycle.
// Master drives the ports; the RAM uses the slave modport.
interface memory_sdpram_if #(
    parameter int ADDR_WIDTH       = 8,
    parameter int DATA_WIDTH       = 32,
    parameter int BYTE_WRITE_WIDTH = 32
);
    localparam int LANES = DATA_WIDTH / BYTE_WRITE_WIDTH;

    logic                  ena;
    logic [LANES-1:0]      wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic                  enb;
    logic                  regceb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] doutb;

    modport master (
        output ena, wea, addra, dina, enb, regceb, addrb,
        input  doutb
    );

    modport slave (
        input  ena, wea, addra, dina, enb, regceb, addrb,
        output doutb
    );
endinterface

// File: rtl/memory_sdpram.sv
// Single-clock simple dual-port RAM: byte-lane writes on A, registered reads on B.
// Latency: READ_LATENCY (1 or 2) edges from addrb to doutb.
// Backpressure: none; enb/regceb only gate the read registers.
module memory_sdpram #(
    parameter int                    ADDR_WIDTH       = 8,
    parameter int                    DATA_WIDTH       = 32,
    parameter int                    BYTE_WRITE_WIDTH = 32,
    parameter string                 WRITE_MODE       = "write_first",
    parameter int                    READ_LATENCY     = 1,
    parameter logic [DATA_WIDTH-1:0] READ_RESET_VALUE = '0
) (
    input logic             clka,
    input logic             rstb,
    memory_sdpram_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / BYTE_WRITE_WIDTH;
    localparam bit IS_WF = (WRITE_MODE == "write_first");
    localparam bit IS_NC = (WRITE_MODE == "no_change");

    if ((DATA_WIDTH % BYTE_WRITE_WIDTH) != 0) begin : g_bad_lane
        $error("memory_sdpram: BYTE_WRITE_WIDTH must divide DATA_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
        $error("memory_sdpram: READ_LATENCY must be 1 or 2");
    end
    if (WRITE_MODE != "write_first" && WRITE_MODE != "read_first" &&
        WRITE_MODE != "no_change") begin : g_bad_mode
        $error("memory_sdpram: WRITE_MODE must be write_first, read_first or no_change");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] stage1_q;
    logic                  collide;

    assign collide = bus.ena && bus.enb && (bus.addra == bus.addrb);

    always_ff @(posedge clka) begin
        if (bus.ena) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wea[i]) begin
                    mem[bus.addra][i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] <=
                        bus.dina[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
                end
            end
        end
    end

    // write_first bypasses only the lanes being written this edge
    always_comb begin
        rd_word = mem[bus.addrb];
        if (IS_WF && collide) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wea[i]) begin
                    rd_word[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] =
                        bus.dina[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clka or posedge rstb) begin
        if (rstb) begin
            stage1_q <= READ_RESET_VALUE;
        end else if (bus.enb && !(IS_NC && collide)) begin
            stage1_q <= rd_word;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] dout_q;

        always_ff @(posedge clka or posedge rstb) begin
            if (rstb) begin
                dout_q <= READ_RESET_VALUE;
            end else if (bus.regceb) begin
                dout_q <= stage1_q;
            end
        end
        assign bus.doutb = dout_q;
    end else begin : g_lat1
        logic unused_regceb;
        assign unused_regceb = bus.regceb;
        assign bus.doutb     = stage1_q;
    end
endmodule

// File: tb/tb_memory_sdpram.sv
// Scoreboard bench: three RAM configurations share one stimulus stream and one reference memory.
module tb_memory_sdpram;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int LN = DW / BW;
    localparam int ND = 3;
    localparam logic [DW-1:0] RRV2 = 32'hA5A5_0F0F;

    typedef struct {
        int                   cyc;
        logic [ND-1:0][DW-1:0] e;
    } exp_t;

    logic clka = 1'b0;
    logic rstb;

    memory_sdpram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WRITE_WIDTH(BW)) if0 ();
    memory_sdpram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WRITE_WIDTH(BW)) if1 ();
    memory_sdpram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WRITE_WIDTH(BW)) if2 ();

    memory_sdpram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WRITE_WIDTH(BW),
                    .WRITE_MODE("write_first"), .READ_LATENCY(1), .READ_RESET_VALUE('0))
        d0 (.clka(clka), .rstb(rstb), .bus(if0));
    memory_sdpram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WRITE_WIDTH(BW),
                    .WRITE_MODE("read_first"), .READ_LATENCY(2), .READ_RESET_VALUE('0))
        d1 (.clka(clka), .rstb(rstb), .bus(if1));
    memory_sdpram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WRITE_WIDTH(BW),
                    .WRITE_MODE("no_change"), .READ_LATENCY(1), .READ_RESET_VALUE(RRV2))
        d2 (.clka(clka), .rstb(rstb), .bus(if2));

    always #5 clka = ~clka;

    // Reference: mode 0 write_first, 1 read_first, 2 no_change
    int              mode   [ND] = '{0, 1, 2};
    int              lat    [ND] = '{1, 2, 1};
    logic [DW-1:0]   rrv    [ND] = '{32'h0, 32'h0, RRV2};
    logic [DW-1:0]   mem_m  [1<<AW];
    logic [DW-1:0]   s1_m   [ND];
    logic [DW-1:0]   out_m  [ND];

    exp_t sb_q[$];
    exp_t imm_q[$];
    event imm_ev;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [DW-1:0] dout_of(input int k);
        case (k)
            0:       return if0.doutb;
            1:       return if1.doutb;
            default: return if2.doutb;
        endcase
    endfunction

    task automatic compare(input exp_t x, input string where);
        logic [DW-1:0] got;
        for (int k = 0; k < ND; k++) begin
            got = dout_of(k);
            checks++;
            if (got !== x.e[k]) begin
                errors++;
                $display("FAIL %s dut%0d cyc=%0d doutb=%h expected=%h", where, k, x.cyc, got, x.e[k]);
            end
        end
    endtask

    // Edge monitor: checks every expectation due at this edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clka);
            #1;
            cyc++;
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                x = sb_q.pop_front();
                compare(x, "edge");
            end
        end
    end

    // Asynchronous monitor: checks between edges around reset changes
    initial begin
        exp_t x;
        forever begin
            @(imm_ev);
            while (imm_q.size() > 0) begin
                x = imm_q.pop_front();
                compare(x, "async_rst");
            end
        end
    end

    task automatic set_rst(input logic v);
        exp_t x;
        rstb = v;
        if (v) begin
            for (int k = 0; k < ND; k++) begin
                s1_m[k]  = rrv[k];
                out_m[k] = rrv[k];
            end
        end
        #1;
        x.cyc = cyc;
        for (int k = 0; k < ND; k++) x.e[k] = out_m[k];
        imm_q.push_back(x);
        ->imm_ev;
        #1;
    endtask

    task automatic drive(input logic ena, input logic [LN-1:0] wea, input logic [AW-1:0] addra,
                         input logic [DW-1:0] dina, input logic enb, input logic regceb,
                         input logic [AW-1:0] addrb);
        logic [DW-1:0] old_w;
        logic [DW-1:0] new_w;
        bit            coll;
        exp_t          x;
        if0.ena = ena; if0.wea = wea; if0.addra = addra; if0.dina = dina;
        if0.enb = enb; if0.regceb = regceb; if0.addrb = addrb;
        if1.ena = ena; if1.wea = wea; if1.addra = addra; if1.dina = dina;
        if1.enb = enb; if1.regceb = regceb; if1.addrb = addrb;
        if2.ena = ena; if2.wea = wea; if2.addra = addra; if2.dina = dina;
        if2.enb = enb; if2.regceb = regceb; if2.addrb = addrb;

        // Words before and after this edge's write; write_first sees "after", read_first "before"
        old_w = mem_m[addrb];
        if (ena) begin
            for (int i = 0; i < LN; i++) begin
                if (wea[i]) mem_m[addra][i*BW +: BW] = dina[i*BW +: BW];
            end
        end
        new_w = mem_m[addrb];
        coll  = ena && enb && (addra == addrb);

        if (!rstb) begin
            for (int k = 0; k < ND; k++) begin
                if (lat[k] == 2 && regceb) out_m[k] = s1_m[k];
                if (enb) begin
                    if (mode[k] == 0)      s1_m[k] = new_w;
                    else if (mode[k] == 1) s1_m[k] = old_w;
                    else if (!coll)        s1_m[k] = old_w;
                end
                if (lat[k] == 1) out_m[k] = s1_m[k];
            end
        end
        x.cyc = cyc + 1;
        for (int k = 0; k < ND; k++) x.e[k] = out_m[k];
        sb_q.push_back(x);
        @(posedge clka);
        #3;
    endtask

    task automatic idle(input logic regceb);
        drive(1'b0, '0, '0, '0, 1'b0, regceb, '0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        for (int a = 0; a < (1 << AW); a++) mem_m[a] = '0;
        rstb = 1'b1;
        for (int k = 0; k < ND; k++) begin
            s1_m[k]  = rrv[k];
            out_m[k] = rrv[k];
        end
        if0.ena = 0; if0.wea = '0; if0.addra = '0; if0.dina = '0; if0.enb = 0; if0.regceb = 0; if0.addrb = '0;
        if1.ena = 0; if1.wea = '0; if1.addra = '0; if1.dina = '0; if1.enb = 0; if1.regceb = 0; if1.addrb = '0;
        if2.ena = 0; if2.wea = '0; if2.addra = '0; if2.dina = '0; if2.enb = 0; if2.regceb = 0; if2.addrb = '0;
        @(posedge clka);
        #3;

        // Reset held: reads of addr 5 ignored, then first read after release
        set_rst(1'b1);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 8'd5);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 8'd5);
        set_rst(1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 8'd5);
        idle(1'b1);

        // Word write then read
        drive(1'b1, 4'hF, 8'd3, 32'hDEAD_BEEF, 1'b0, 1'b1, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 8'd3);
        idle(1'b1);

        // Byte-lane write
        drive(1'b1, 4'hF, 8'd7, 32'h1122_3344, 1'b0, 1'b1, '0);
        drive(1'b1, 4'b0010, 8'd7, 32'hAABB_CCDD, 1'b0, 1'b1, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 8'd7);
        idle(1'b1);

        // Collision on addr 9, then a clean re-read
        drive(1'b1, 4'hF, 8'd9, 32'h0000_0055, 1'b1, 1'b1, 8'd9);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 8'd9);
        idle(1'b1);

        // Enable gating
        for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, '0, 1'b0, 1'b1, AW'($urandom));
        drive(1'b1, 4'h0, 8'd2, 32'hFFFF_FFFF, 1'b0, 1'b1, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 8'd2);
        idle(1'b1);

        // Second-stage clock enable
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 8'd3);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);

        // Reset while data is in stage 1
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 8'd7);
        set_rst(1'b1);
        set_rst(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Random traffic on a narrow address window to force collisions
        for (int n = 0; n < 400; n++) begin
            ra = AW'($urandom_range(0, 15));
            drive(1'($urandom), LN'($urandom), AW'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), ra);
            if ($urandom_range(0, 39) == 0) begin
                set_rst(1'b1);
                set_rst(1'b0);
            end else if ($urandom_range(0, 59) == 0) begin
                set_rst(1'b1);
                drive(1'b1, LN'($urandom), AW'($urandom_range(0, 15)), $urandom, 1'b1, 1'b1, ra);
                set_rst(1'b0);
            end
        end

        repeat (3) @(posedge clka);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/memory_sdpram.md
Name: memory_sdpram

Overview:
- Single-clock simple dual-port RAM: port A is write-only, with per-byte write enables; port B is read-only, with a registered output.
- Used as the generic block-RAM primitive underneath the design's RAM wrappers (caches, queues, tables).
- Behaviour is fully synthesizable and deterministic, including the same-address read/write collision.

Parameters:
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width in bits.
- BYTE_WRITE_WIDTH, 32, bits per write-enable lane; must divide DATA_WIDTH; equal to DATA_WIDTH means word-wide writes.
- WRITE_MODE, "write_first", collision policy; legal values "write_first", "read_first", "no_change".
- READ_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- READ_RESET_VALUE, 0, DATA_WIDTH value loaded into the output register(s) on reset.

Ports:
- clka  in  1  single clock for both ports, rising edge.
- rstb  in  1  asynchronous, active-high reset of the port-B output pipeline only.
- ena  in  1  port A enable; a write occurs only when ena is high.
- wea  in  DATA_WIDTH/BYTE_WRITE_WIDTH  byte-lane write enables; bit i covers dina[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH].
- addra  in  ADDR_WIDTH  write address.
- dina  in  DATA_WIDTH  write data.
- enb  in  1  port B read enable.
- regceb  in  1  clock enable of the final output register; used only when READ_LATENCY=2.
- addrb  in  ADDR_WIDTH  read address.
- doutb  out  DATA_WIDTH  read data.

Behaviour:
- Memory array initialises to all zeros at time 0 / configuration. It has no reset; rstb never alters its contents.
- Write: at posedge clka, if ena=1, each lane i with wea[i]=1 is written from dina into mem[addra]. Lanes with wea[i]=0 keep their contents. ena=0 or wea=0 means no write.
- Read, READ_LATENCY=1:
  - At posedge clka with enb=1, doutb <= mem[addrb], subject to the collision rule.
  - With enb=0, doutb holds its value.
- Read, READ_LATENCY=2:
  - Stage 1 register loads as above when enb=1.
  - doutb register loads stage 1 at posedge when regceb=1, otherwise holds.
  - Data appears 2 cycles after the address when regceb is held high.
- Collision (enb=1, ena=1, addra==addrb, same edge), applied per lane:
  - "write_first": a lane being written returns new dina; other lanes return old contents.
  - "read_first": all lanes return old contents.
  - "no_change": the read register holds its previous value (the read is suppressed); the write still completes.
- Reset:
  - rstb=1 immediately forces doutb and the stage-1 register to READ_RESET_VALUE, independent of clka.
  - While rstb=1 the output registers stay at the reset value; reads are ignored.
  - Writes on port A proceed normally during reset.
  - The first read after rstb deasserts behaves normally on the next rising edge.
- Mid-operation reset in latency 2: in-flight stage-1 data is discarded.
- Address wrap: addresses cover the full 2**ADDR_WIDTH range; there is no out-of-range case.
- No X propagation from uninitialised storage, since all words start at zero.
- Elaboration error if DATA_WIDTH % BYTE_WRITE_WIDTH != 0, READ_LATENCY is not 1 or 2, or WRITE_MODE is illegal.

Test Plan:
- Reset then read with rstb pulsed high, enb=1, addrb=5 -> doutb=READ_RESET_VALUE (0) during reset; one edge after release doutb=0 (initial contents).
- Word write/read, latency 1: write 0xDEADBEEF to addr 3 (wea all 1), next cycle read addr 3 -> doutb=0xDEADBEEF exactly one edge after addrb is applied.
- Byte-lane write, BYTE_WRITE_WIDTH=8: mem[7]=0x11223344, then write dina=0xAABBCCDD with wea=4'b0010 -> read returns 0x1122CC44.
- Collision per mode: mem[9]=0x0, then same-cycle write 0x55 and read addr 9:
  - write_first -> doutb=0x55.
  - read_first -> doutb=0x0.
  - no_change -> doutb keeps its prior value.
  - Next read of addr 9 returns 0x55 in all modes.
- Enable gating: enb=0 with a changing addrb -> doutb holds; ena=1, wea=0 write to addr 2 -> mem[2] unchanged (reads 0).
- Latency 2 with regceb: read addr 3 (0xDEADBEEF) -> appears after 2 edges; with regceb=0 on the second edge, doutb holds the old value until regceb=1; asserting rstb mid-pipeline -> doutb=0 and the in-flight data is dropped.
